// File: rtl/mem_bus_pkg.sv
// Shared types, access-size codes and byte-lane helper for the bus-side
// memory controller.
package mem_bus_pkg;

    // Controller states: accept in IDLE/RESP, count wait states in WAIT,
    // strobe the memory in ACCESS, present the response in RESP.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } mem_bus_state_t;

    // Access size codes shared with the core; 2'b11 behaves like a word.
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    // Byte-lane write enables for a little-endian, lane-aligned access.
    // Half-words ignore addr[0]; words ignore both low address bits.
    function automatic logic [3:0] mem_byte_we(input logic [1:0] addr_lo,
                                               input logic [1:0] size);
        case (size)
            MEM_SIZE_BYTE: mem_byte_we = 4'b0001 << addr_lo;
            MEM_SIZE_HALF: mem_byte_we = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:       mem_byte_we = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decoder: finds which memory region a bus address
// falls into. Overlapping regions resolve to the lowest index; a region
// of size zero never matches.
module mem_region_decode
    import mem_bus_pkg::*;
#(
    parameter int                           NUM_REGIONS = 8,
    parameter int                           IDX_W       = 3,
    parameter logic [NUM_REGIONS-1:0][31:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS-1:0][31:0] REGION_SIZE = '0
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Priority encoder: scan from the top so the lowest matching index is
    // the last assignment and therefore wins. The unsigned subtraction
    // wraps addresses below the base to huge values, so a single compare
    // covers both the lower and the upper bound.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((addr - REGION_BASE[i]) < REGION_SIZE[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Bus-side memory controller: decodes CPU/DMA accesses onto per-region
// word-wide BRAM ports, inserts per-region wait states while holding the
// master with bus_pause, generates byte write enables and flags accesses
// that hit no region.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int                           NUM_REGIONS = 8,
    parameter int                           WS_W        = 4,
    parameter logic [NUM_REGIONS-1:0][31:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS-1:0][31:0] REGION_SIZE = '0,
    parameter logic [31:0]                  OPEN_BUS    = 32'h0000_0000
) (
    input  logic                                clock,
    input  logic                                reset_n,

    // CPU/DMA bus side
    input  logic                                bus_req,
    input  logic [31:0]                         bus_addr,
    input  logic [31:0]                         bus_wdata,
    input  logic [1:0]                          bus_size,
    input  logic                                bus_write,
    output logic                                bus_pause,
    output logic [31:0]                         bus_rdata,
    output logic                                bus_rvalid,
    output logic                                bus_err,

    // Wait-state configuration, sampled when a request is accepted
    input  logic [NUM_REGIONS-1:0][WS_W-1:0]    region_ws,

    // Memory side, one port per region sharing address and write data
    output logic [31:0]                         mem_addr,
    output logic [31:0]                         mem_wdata,
    output logic [NUM_REGIONS-1:0][3:0]         mem_we,
    input  logic [NUM_REGIONS-1:0][31:0]        mem_rdata
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    mem_bus_state_t   state;
    logic [WS_W-1:0]  ws_cnt;

    // Attributes of the in-flight access captured at acceptance
    logic             lat_hit;
    logic [IDX_W-1:0] lat_idx;
    logic             lat_write;
    logic [3:0]       lat_be;

    // Decode of the request currently on the bus
    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;
    logic [WS_W-1:0]  acc_ws;
    logic             accept;

    mem_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .IDX_W       (IDX_W),
        .REGION_BASE (REGION_BASE),
        .REGION_SIZE (REGION_SIZE)
    ) u_decode (
        .addr (bus_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Unmapped accesses take no wait states; a request is only taken when
    // the controller is free (IDLE) or finishing the previous one (RESP).
    assign acc_ws = dec_hit ? region_ws[dec_idx] : '0;
    assign accept = bus_req && ((state == ST_IDLE) || (state == ST_RESP));

    // Controller FSM with registered pause/response outputs and the
    // latches for the accepted access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the access latches are reset along with the FSM so an
            // access abandoned by reset leaves nothing stale on mem_addr or
            // mem_wdata and nothing decodes as a pending write.
            state      <= ST_IDLE;
            ws_cnt     <= '0;
            lat_hit    <= 1'b0;
            lat_idx    <= '0;
            lat_write  <= 1'b0;
            lat_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            bus_pause  <= 1'b0;
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below sees the pre-edge values of state and the latches.
            bus_rvalid <= 1'b0;
            bus_err    <= 1'b0;

            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        lat_hit   <= dec_hit;
                        lat_idx   <= dec_idx;
                        lat_write <= bus_write;
                        lat_be    <= mem_byte_we(bus_addr[1:0], bus_size);
                        mem_addr  <= (bus_addr - REGION_BASE[dec_idx]) >> 2;
                        mem_wdata <= bus_wdata;
                        bus_pause <= 1'b1;
                        if (acc_ws != '0) begin
                            state  <= ST_WAIT;
                            ws_cnt <= acc_ws;
                        end else begin
                            state  <= ST_ACCESS;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        bus_pause <= 1'b0;
                    end
                end

                // The last wait cycle is the one where the counter reads 1,
                // giving exactly ws wait cycles ahead of ACCESS.
                ST_WAIT: begin
                    ws_cnt <= ws_cnt - 1'b1;
                    if (ws_cnt == WS_W'(1)) begin
                        state <= ST_ACCESS;
                    end
                end

                // Write enables are live this cycle; read data is captured
                // on the way out. Writes leave bus_rdata untouched.
                ST_ACCESS: begin
                    state      <= ST_RESP;
                    bus_pause  <= 1'b0;
                    bus_rvalid <= 1'b1;
                    bus_err    <= !lat_hit;
                    if (!lat_write) begin
                        bus_rdata <= lat_hit ? mem_rdata[lat_idx] : OPEN_BUS;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    bus_pause <= 1'b0;
                end
            endcase
        end
    end

    // Byte write enables: only the hit region, only for a mapped write,
    // only during the single ACCESS cycle. Derived from registered state so
    // reset clears them at once.
    always_comb begin
        mem_we = '0;
        if ((state == ST_ACCESS) && lat_hit && lat_write) begin
            mem_we[lat_idx] = lat_be;
        end
    end

endmodule
